qupls_sched_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle ROB issue scheduler.
- Scans a WINDOW-entry age-ordered slice of the ROB starting at head and picks the oldest eligible entry for each of NCH issue channels.
- Issue decisions are registered, so the scan is not a combinational path into the functional units.
- Adds per-channel busy countdown for multi-cycle operations, a one-cycle re-issue mask, a window-relative sync barrier, stall and flush.

---
 rtl/qupls_sched_pipe_pkg.sv | 24 ++
 rtl/qupls_sched_pipe_if.sv | 35 +++
 rtl/qupls_sched_pipe_pick.sv | 34 +++
 rtl/qupls_sched_pipe.sv | 130 +++++++++++++
 tb/tb_qupls_sched_pipe.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/qupls_sched_pipe_pkg.sv
// qupls_sched_pipe_pkg: shared ROB index/mask types, FU class encoding and default channel class map.
package qupls_sched_pipe_pkg;
    localparam int ROB_ENTRIES = 16;
    localparam int FU_CLASSES  = 4;

    typedef logic [$clog2(ROB_ENTRIES)-1:0] rob_ndx_t;
    typedef logic [ROB_ENTRIES-1:0]         rob_bitmask_t;

    typedef enum logic [1:0] {
        FUC_ALU  = 2'd0,
        FUC_FPU  = 2'd1,
        FUC_FCU  = 2'd2,
        FUC_AGEN = 2'd3
    } fu_class_t;

    function automatic logic [FU_CLASSES-1:0] fuc_bit(input fu_class_t c);
        fuc_bit    = '0;
        fuc_bit[c] = 1'b1;
    endfunction

    // channel 0 sits in the low nibble: ch0 ALU, ch1 ALU, ch2 FPU, ch3 AGEN
    localparam logic [4*FU_CLASSES-1:0] CH_CLASS_DEF =
        {fuc_bit(FUC_AGEN), fuc_bit(FUC_FPU), fuc_bit(FUC_ALU), fuc_bit(FUC_ALU)};
endpackage

// File: rtl/qupls_sched_pipe_if.sv
// qupls_sched_pipe_if: ROB-state inputs and registered issue outputs of the pipelined scheduler.
interface qupls_sched_pipe_if
    import qupls_sched_pipe_pkg::*;
#(
    parameter int ROBN   = ROB_ENTRIES,
    parameter int NCH    = 4,
    parameter int NCLASS = FU_CLASSES,
    parameter int LATW   = 4
);
    localparam int NW = $clog2(ROBN);

    logic                   flush;
    logic                   stall;
    logic [NW-1:0]          head;
    logic [ROBN-1:0]        valid;
    logic [ROBN-1:0]        ready;
    logic [ROBN-1:0]        sync;
    logic [ROBN*NCLASS-1:0] cls;
    logic [ROBN*LATW-1:0]   lat;
    logic [NCH-1:0]         ch_en;
    logic [NCH-1:0]         iss_v;
    logic [NCH*NW-1:0]      iss_ndx;
    logic [ROBN-1:0]        iss_mask;
    logic [NCH-1:0]         ch_busy;

    modport master (
        output flush, stall, head, valid, ready, sync, cls, lat, ch_en,
        input  iss_v, iss_ndx, iss_mask, ch_busy
    );

    modport slave (
        input  flush, stall, head, valid, ready, sync, cls, lat, ch_en,
        output iss_v, iss_ndx, iss_mask, ch_busy
    );
endinterface

// File: rtl/qupls_sched_pipe_pick.sv
// qupls_sched_pick: oldest-first pick over the scan window for one channel's class mask,
// passing its exclusion mask on to the next channel.
module qupls_sched_pick
    import qupls_sched_pipe_pkg::*;
#(
    parameter int WINDOW = 16,
    parameter int NCLASS = FU_CLASSES,
    parameter int PW     = 4
) (
    input  logic                     i_en,
    input  logic [WINDOW-1:0]        i_elig,
    input  logic [WINDOW*NCLASS-1:0] i_cls,
    input  logic [NCLASS-1:0]        i_mask,
    input  logic [WINDOW-1:0]        i_excl,
    output logic                     o_found,
    output logic [PW-1:0]            o_pos,
    output logic [WINDOW-1:0]        o_excl
);
    logic [WINDOW-1:0] w_cand;

    for (genvar m = 0; m < WINDOW; m++) begin : g_cand
        assign w_cand[m] = i_en & i_elig[m] & ~i_excl[m] & |(i_cls[m*NCLASS +: NCLASS] & i_mask);
    end

    assign o_found = |w_cand;
    // lowest set bit of the candidates is the oldest one
    assign o_excl  = i_excl | (w_cand & (~w_cand + WINDOW'(1)));

    always_comb begin
        o_pos = '0;
        for (int m = WINDOW - 1; m >= 0; m--)
            o_pos = w_cand[m] ? PW'(m) : o_pos;
    end
endmodule

// File: rtl/qupls_sched_pipe.sv
// qupls_sched_pipe: pipelined oldest-first ROB issue scheduler; scans WINDOW entries from head
// and registers one pick per channel, with busy countdowns, re-issue mask, sync barrier, stall and flush.
module qupls_sched_pipe
    import qupls_sched_pipe_pkg::*;
#(
    parameter int                    ROBN     = ROB_ENTRIES,
    parameter int                    WINDOW   = 16,
    parameter int                    NCH      = 4,
    parameter int                    NCLASS   = FU_CLASSES,
    parameter int                    LATW     = 4,
    parameter logic [NCH*NCLASS-1:0] CH_CLASS = CH_CLASS_DEF
) (
    input logic               clk,
    input logic               rst_n,
    qupls_sched_pipe_if.slave io_sch
);
    localparam int NW = $clog2(ROBN);
    localparam int PW = WINDOW > 1 ? $clog2(WINDOW) : 1;

    if (WINDOW > ROBN) begin : g_window_check
        $error("qupls_sched_pipe: WINDOW (%0d) exceeds ROBN (%0d)", WINDOW, ROBN);
    end

    logic [NCLASS-1:0]        w_rcls [ROBN];
    logic [LATW-1:0]          w_rlat [ROBN];
    logic [NW-1:0]            w_idx  [WINDOW];
    logic [LATW-1:0]          w_wlat [WINDOW];
    logic [WINDOW*NCLASS-1:0] w_wcls;
    logic [WINDOW-1:0]        w_live, w_vsync, w_blk, w_elig, w_taken;
    logic [PW-1:0]            w_pos  [NCH];
    logic [NCH-1:0]           w_free, w_found;
    logic [ROBN-1:0]          w_mask;
    logic [NCH-1:0]           r_iss_v;
    logic [NW-1:0]            r_iss_ndx [NCH];
    logic [ROBN-1:0]          r_iss_mask;
    logic [LATW-1:0]          r_busy    [NCH];

    for (genvar r = 0; r < ROBN; r++) begin : g_rob
        assign w_rcls[r] = io_sch.cls[r*NCLASS +: NCLASS];
        assign w_rlat[r] = io_sch.lat[r*LATW +: LATW];
    end

    for (genvar m = 0; m < WINDOW; m++) begin : g_win
        logic [NW:0] w_sum;
        // head < ROBN and m < ROBN, so one conditional subtract wraps the index
        assign w_sum    = {1'b0, io_sch.head} + (NW+1)'(m);
        assign w_idx[m] = w_sum >= (NW+1)'(ROBN) ? NW'(w_sum - (NW+1)'(ROBN)) : w_sum[NW-1:0];
        assign w_live[m]  = io_sch.valid[w_idx[m]] & io_sch.ready[w_idx[m]] & ~r_iss_mask[w_idx[m]];
        assign w_vsync[m] = io_sch.valid[w_idx[m]] & io_sch.sync[w_idx[m]];
        assign w_wcls[m*NCLASS +: NCLASS] = w_rcls[w_idx[m]];
        assign w_wlat[m] = w_rlat[w_idx[m]];
        if (m == 0) begin : g_head
            assign w_elig[m] = w_live[m];
        end else begin : g_tail
            // w_blk[m] covers a sync at m itself as well as any older one
            assign w_elig[m] = w_live[m] & ~w_blk[m];
        end
    end

    always_comb begin
        w_blk = w_vsync;
        for (int m = 1; m < WINDOW; m++)
            w_blk[m] = w_blk[m-1] | w_vsync[m];
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [WINDOW-1:0] w_xin, w_xout;
        if (c == 0) begin : g_x0
            assign w_xin = '0;
        end else begin : g_xn
            assign w_xin = g_ch[c-1].w_xout;
        end
        assign w_free[c] = io_sch.ch_en[c] & ~|r_busy[c] & ~io_sch.stall;
        qupls_sched_pick #(
            .WINDOW (WINDOW),
            .NCLASS (NCLASS),
            .PW     (PW)
        ) u_pick (
            .i_en    (w_free[c]),
            .i_elig  (w_elig),
            .i_cls   (w_wcls),
            .i_mask  (CH_CLASS[c*NCLASS +: NCLASS]),
            .i_excl  (w_xin),
            .o_found (w_found[c]),
            .o_pos   (w_pos[c]),
            .o_excl  (w_xout)
        );
        assign io_sch.iss_ndx[c*NW +: NW] = r_iss_ndx[c];
        assign io_sch.ch_busy[c]          = |r_busy[c];
    end

    assign w_taken = g_ch[NCH-1].w_xout;

    always_comb begin
        w_mask = '0;
        for (int m = 0; m < WINDOW; m++)
            w_mask[w_idx[m]] = w_mask[w_idx[m]] | w_taken[m];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_iss_v    <= '0;
            r_iss_mask <= '0;
            for (int c = 0; c < NCH; c++) begin
                r_iss_ndx[c] <= '0;
                r_busy[c]    <= '0;
            end
        end else begin
            if (io_sch.flush) begin
                r_iss_v    <= '0;
                r_iss_mask <= '0;
            end else if (!io_sch.stall) begin
                r_iss_v    <= w_found;
                r_iss_mask <= w_mask;
            end
            // a flushed pick never occupies its unit; running countdowns keep draining
            for (int c = 0; c < NCH; c++) begin
                if (w_found[c] && !io_sch.flush) begin
                    r_iss_ndx[c] <= w_idx[w_pos[c]];
                    r_busy[c]    <= w_wlat[w_pos[c]] >= LATW'(2) ? w_wlat[w_pos[c]] - LATW'(1) : '0;
                end else if (r_busy[c] != '0) begin
                    r_busy[c] <= r_busy[c] - LATW'(1);
                end
            end
        end
    end

    assign io_sch.iss_v    = r_iss_v;
    assign io_sch.iss_mask = r_iss_mask;
endmodule

// File: tb/tb_qupls_sched_pipe.sv
// tb_qupls_sched_pipe: directed vectors for the pipelined scheduler; expectations are queued as
// stimulus is issued and a negedge monitor pops and compares them against the registered outputs.
module tb_qupls_sched_pipe;
    import qupls_sched_pipe_pkg::*;

    localparam logic [3:0] ALU = fuc_bit(FUC_ALU);
    localparam logic [3:0] FPU = fuc_bit(FUC_FPU);
    localparam logic [3:0] AA  = fuc_bit(FUC_ALU) | fuc_bit(FUC_AGEN);

    typedef struct {
        string        nm;
        logic [3:0]   v;
        logic [15:0]  ndx;
        rob_bitmask_t mask;
        logic [3:0]   busy;
        logic [3:0]   nchk;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n;
    exp_t  q[$];
    exp_t  e;
    logic [15:0] ndx_bits;
    int    n_checks = 0;
    int    n_errs   = 0;

    qupls_sched_pipe_if #(.ROBN(16), .NCH(4), .NCLASS(4), .LATW(4)) sif ();

    qupls_sched_pipe #(
        .ROBN   (16),
        .WINDOW (16),
        .NCH    (4),
        .NCLASS (4),
        .LATW   (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_sch (sif)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input string f, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s %s: got %h, expected %h", nm, f, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            chk(e.nm, "iss_v", {12'b0, sif.iss_v}, {12'b0, e.v});
            ndx_bits = '0;
            for (int c = 0; c < 4; c++)
                if (e.nchk[c]) ndx_bits[c*4 +: 4] = 4'hF;
            if (e.nchk != 4'b0)
                chk(e.nm, "iss_ndx", sif.iss_ndx & ndx_bits, e.ndx & ndx_bits);
            chk(e.nm, "iss_mask", sif.iss_mask, e.mask);
            chk(e.nm, "ch_busy", {12'b0, sif.ch_busy}, {12'b0, e.busy});
        end
    end

    task automatic cyc(input string nm, input logic [3:0] v, input logic [15:0] ndx,
                       input logic [15:0] mask, input logic [3:0] busy, input logic [3:0] nchk);
        exp_t x;
        @(posedge clk);
        x.nm   = nm;
        x.v    = v;
        x.ndx  = ndx;
        x.mask = mask;
        x.busy = busy;
        x.nchk = nchk;
        q.push_back(x);
        #1;
    endtask

    task automatic cv(input string nm, input logic [3:0] v, input logic [15:0] ndx,
                      input logic [15:0] mask, input logic [3:0] busy);
        cyc(nm, v, ndx, mask, busy, v);
    endtask

    task automatic clr();
        sif.valid = '0;
        sif.ready = '0;
        sif.sync  = '0;
        sif.cls   = '0;
        sif.lat   = '0;
        sif.flush = 1'b0;
        sif.stall = 1'b0;
        sif.head  = '0;
        sif.ch_en = 4'hF;
    endtask

    task automatic ent(input int i, input logic [3:0] c, input logic [3:0] l, input logic s);
        sif.valid[i]       = 1'b1;
        sif.ready[i]       = 1'b1;
        sif.sync[i]        = s;
        sif.cls[i*4 +: 4]  = c;
        sif.lat[i*4 +: 4]  = l;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        sif.head  = '0;
        sif.valid = '1;
        sif.ready = '1;
        sif.sync  = '0;
        sif.cls   = {16{4'b1011}};
        sif.lat   = {16{4'h4}};
        sif.ch_en = 4'hF;
        sif.flush = 1'b1;
        sif.stall = 1'b0;
        cv("reset0", 4'b0000, 16'h0000, 16'h0000, 4'b0000);
        sif.flush = 1'b0;
        cv("reset1", 4'b0000, 16'h0000, 16'h0000, 4'b0000);
        rst_n = 1'b1;
        clr();
        cv("empty", 4'b0000, 16'h0000, 16'h0000, 4'b0000);

        // wrap-around: head 14, entries 14, 15, 0
        sif.head = 4'd14;
        ent(14, ALU, 4'd1, 1'b0);
        ent(15, ALU, 4'd1, 1'b0);
        ent(0,  ALU, 4'd1, 1'b0);
        cv("wrap_pick",   4'b0011, 16'h00FE, 16'hC000, 4'b0000);
        cv("wrap_masked", 4'b0001, 16'h0000, 16'h0001, 4'b0000);
        sif.ready = '0;
        cv("wrap_drain",  4'b0000, 16'h0000, 16'h0000, 4'b0000);

        // sync barrier at 5
        clr();
        sif.head = 4'd3;
        ent(4, ALU, 4'd1, 1'b0);
        ent(5, ALU, 4'd1, 1'b1);
        ent(6, ALU, 4'd1, 1'b0);
        sif.ready[5] = 1'b0;
        cv("sync_before", 4'b0001, 16'h0004, 16'h0010, 4'b0000);
        sif.ready[4] = 1'b0;
        sif.head     = 4'd5;
        sif.ready[5] = 1'b1;
        cv("sync_at_head", 4'b0001, 16'h0005, 16'h0020, 4'b0000);
        sif.ready[5] = 1'b0;
        cv("sync_blocks", 4'b0000, 16'h0000, 16'h0000, 4'b0000);
        sif.valid[5] = 1'b0;
        sif.sync[5]  = 1'b0;
        sif.head     = 4'd6;
        cv("sync_retired", 4'b0001, 16'h0006, 16'h0040, 4'b0000);

        // multi-cycle FPU on channel 2
        clr();
        ent(0, FPU, 4'd4, 1'b0);
        ent(1, FPU, 4'd2, 1'b0);
        cv("fpu_issue", 4'b0100, 16'h0000, 16'h0001, 4'b0100);
        sif.ready[0] = 1'b0;
        cv("fpu_busy_a", 4'b0000, 16'h0000, 16'h0000, 4'b0100);
        cv("fpu_busy_b", 4'b0000, 16'h0000, 16'h0000, 4'b0100);
        cv("fpu_fall",   4'b0000, 16'h0000, 16'h0000, 4'b0000);
        cv("fpu_second", 4'b0100, 16'h0100, 16'h0002, 4'b0100);
        sif.ready[1] = 1'b0;
        cv("fpu_end",    4'b0000, 16'h0000, 16'h0000, 4'b0000);

        // stall and flush
        clr();
        ent(0, ALU, 4'd1, 1'b0);
        ent(1, ALU, 4'd1, 1'b0);
        ent(2, FPU, 4'd3, 1'b0);
        cv("sf_issue", 4'b0111, 16'h0210, 16'h0007, 4'b0100);
        sif.stall = 1'b1;
        ent(3, ALU, 4'd1, 1'b0);
        cv("stall_hold1", 4'b0111, 16'h0210, 16'h0007, 4'b0100);
        cv("stall_hold2", 4'b0111, 16'h0210, 16'h0007, 4'b0000);
        sif.stall = 1'b0;
        sif.ready[0] = 1'b0;
        sif.ready[1] = 1'b0;
        sif.ready[2] = 1'b0;
        ent(4, FPU, 4'd3, 1'b0);
        sif.flush = 1'b1;
        cyc("flush_new_sel", 4'b0000, 16'h0210, 16'h0000, 4'b0000, 4'b0111);
        sif.flush = 1'b0;
        cv("after_flush", 4'b0101, 16'h0403, 16'h0018, 4'b0100);
        sif.flush = 1'b1;
        sif.stall = 1'b1;
        sif.ready[3] = 1'b0;
        sif.ready[4] = 1'b0;
        cyc("flush_over_stall", 4'b0000, 16'h0403, 16'h0000, 4'b0100, 4'b0101);
        sif.flush = 1'b0;
        sif.stall = 1'b0;
        cv("flush_done", 4'b0000, 16'h0000, 16'h0000, 4'b0000);

        // exclusivity across channels
        clr();
        for (int i = 0; i < 8; i++) ent(i, AA, 4'd1, 1'b0);
        cv("excl_a", 4'b1011, 16'h2010, 16'h0007, 4'b0000);
        for (int i = 0; i < 3; i++) sif.ready[i] = 1'b0;
        cv("excl_b", 4'b1011, 16'h5043, 16'h0038, 4'b0000);
        for (int i = 3; i < 6; i++) sif.ready[i] = 1'b0;
        sif.ch_en = 4'b1110;
        cv("excl_chen", 4'b1010, 16'h7060, 16'h00C0, 4'b0000);

        // reset while a unit is busy
        clr();
        ent(0, FPU, 4'd8, 1'b0);
        cv("rst_busy", 4'b0100, 16'h0000, 16'h0001, 4'b0100);
        rst_n = 1'b0;
        cv("rst_mid", 4'b0000, 16'h0000, 16'h0000, 4'b0000);
        rst_n = 1'b1;
        clr();
        cv("rst_after", 4'b0000, 16'h0000, 16'h0000, 4'b0000);

        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_errs++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
